// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - md_state_e    : sequencer states (idle, multiply, divide, sign fix-up)
//   - MD_WIDTH      : default operand / HI / LO width
//   - MD_ITER       : iterations of the shift-add / restoring loops
//   - HILO_HI/LO    : encodings of the HI/LO select inputs
//   - DIV_ZERO_QUOT : quotient written to LO by a divide by zero
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITER  = MD_WIDTH;

    localparam logic HILO_HI = 1'b1;
    localparam logic HILO_LO = 1'b0;

    localparam logic [MD_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// One restoring-divide step (purely combinational).
// Ports:
//   rem      : partial remainder, always < divisor when divisor != 0
//   dvd_bit  : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this step
//   quot_bit : quotient bit produced by this step
module md_div_step
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quot_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    assign shifted  = {rem, dvd_bit};
    // The true difference is below the divisor whenever it is kept, so W bits suffice.
    assign trial    = shifted[WIDTH-1:0] - divisor;
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign rem_next = quot_bit ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   md_start     : launch pulse; md_div / md_signed select the operation
//   md_abort     : cancels an in-flight operation, HI/LO untouched
//   src_a, src_b : operands (src_a is also MTHI/MTLO data)
//   hilo_wr_dis  : [1] blocks HI move write, [0] blocks LO move write
//   hilo_src     : move target (HILO_HI / HILO_LO)
//   hilo_wr      : move write strobe, honoured only while idle
//   hilo_sel     : read select for hilo_out
//   md_run       : busy
//   hilo_out     : registered HI or LO
//   div_by_zero  : sticky, set by a completed divide with zero divisor
// Optional build macro MD_FAST_MUL_EN: single-cycle magnitude multiply
// (MUL lasts one cycle); results are identical to the iterative build.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_div,
    input  logic             md_signed,
    input  logic             md_abort,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       hilo_wr_dis,
    input  logic             hilo_src,
    input  logic             hilo_wr,
    input  logic             hilo_sel,
    output logic             md_run,
    output logic [WIDTH-1:0] hilo_out,
    output logic             div_by_zero
);

    // Replicate the package pattern to any width.
    localparam logic [WIDTH-1:0] DivZeroQuot = {WIDTH{DIV_ZERO_QUOT[0]}};

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    // Multiply: {upper partial sum, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               start_ok, last_iter;

    logic [WIDTH-1:0]   div_rem_next;
    logic               div_q_bit;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Signed operands become magnitude + sign; -2^(W-1) maps to unsigned 2^(W-1).
    assign a_neg = md_signed & src_a[WIDTH-1];
    assign b_neg = md_signed & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    assign start_ok  = md_start & ~md_abort & (state_q == StIdle);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifndef MD_FAST_MUL_EN
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
`endif

    md_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem     (acc_q[2*WIDTH-1:WIDTH]),
        .dvd_bit (acc_q[WIDTH-1]),
        .divisor (b_q),
        .rem_next(div_rem_next),
        .quot_bit(div_q_bit)
    );

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = (b_q == '0) ? DivZeroQuot
                    : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    // With a zero divisor the remainder ends up as |dividend|, so re-signing it
    // reproduces the captured dividend.
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (hilo_wr) begin
                    if ((hilo_src == HILO_HI) && !hilo_wr_dis[1]) hi_d = src_a;
                    if ((hilo_src == HILO_LO) && !hilo_wr_dis[0]) lo_d = src_a;
                end
                if (start_ok) begin
                    a_d       = a_mag;
                    b_d       = b_mag;
                    is_div_d  = md_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    acc_d     = md_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    state_d   = md_div ? StDiv : StMul;
                end
            end
            StMul: begin
`ifdef MD_FAST_MUL_EN
                acc_d   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                state_d = StFix;
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = StFix;
`endif
            end
            StDiv: begin
                acc_d = {div_rem_next, acc_q[WIDTH-2:0], div_q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d  = quot_fix;
                    hi_d  = rem_fix;
                    dbz_d = (b_q == '0);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort beats everything in flight, including the FIX write.
        if (md_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign md_run      = (state_q != StIdle);
    assign hilo_out    = (hilo_sel == HILO_HI) ? hi_q : lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal
// expectations plus randomized traffic compared every cycle against an
// arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MD_FAST_MUL_EN
    localparam int LAT_MUL = 2;
`else
    localparam int LAT_MUL = W + 1;
`endif
    localparam int LAT_DIV = W + 1;

    logic          clk = 1'b0;
    logic          reset, md_start, md_div, md_signed, md_abort;
    logic [W-1:0]  src_a, src_b;
    logic [1:0]    hilo_wr_dis;
    logic          hilo_src, hilo_wr, hilo_sel;
    logic          md_run, div_by_zero;
    logic [W-1:0]  hilo_out;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [W-1:0]  m_hi, m_lo;
    logic          m_dbz;
    int            m_left;
    logic [64:0]   p_res;
    logic          model_valid = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .md_div     (md_div),
        .md_signed  (md_signed),
        .md_abort   (md_abort),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_wr_dis(hilo_wr_dis),
        .hilo_src   (hilo_src),
        .hilo_wr    (hilo_wr),
        .hilo_sel   (hilo_sel),
        .md_run     (md_run),
        .hilo_out   (hilo_out),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {div_by_zero, HI, LO} computed with plain integer arithmetic.
    function automatic logic [64:0] model_op(input logic div, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!div) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi        <= '0;
            m_lo        <= '0;
            m_dbz       <= 1'b0;
            m_left      <= 0;
            model_valid <= 1'b1;
        end else if (m_left != 0) begin
            if (md_abort) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi  <= p_res[63:32];
                    m_lo  <= p_res[31:0];
                    m_dbz <= p_res[64];
                end
            end
        end else begin
            if (hilo_wr && hilo_src && !hilo_wr_dis[1]) m_hi <= src_a;
            if (hilo_wr && !hilo_src && !hilo_wr_dis[0]) m_lo <= src_a;
            if (md_start && !md_abort) begin
                p_res  <= model_op(md_div, md_signed, src_a, src_b);
                m_dbz  <= 1'b0;
                m_left <= md_div ? LAT_DIV : LAT_MUL;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("md_run", 32'(md_run), 32'(m_left != 0));
            check("hilo_out", hilo_out, hilo_sel ? m_hi : m_lo);
            check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic div, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b);
        md_start  = 1'b1;
        md_div    = div;
        md_signed = sgn;
        src_a     = a;
        src_b     = b;
        tick();
        md_start  = 1'b0;
    endtask

    // Counts busy cycles until md_run drops, bounded.
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (md_run && n < 200) begin
            n++;
            @(negedge clk);
        end
        tick();
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hilo_sel = 1'b1;
        @(negedge clk);
        hi = hilo_out;
        tick();
        hilo_sel = 1'b0;
        @(negedge clk);
        lo = hilo_out;
        tick();
    endtask

    task automatic move(input logic to_hi, input logic [1:0] dis, input logic [31:0] d);
        hilo_wr     = 1'b1;
        hilo_src    = to_hi;
        hilo_wr_dis = dis;
        src_a       = d;
        tick();
        hilo_wr     = 1'b0;
        hilo_wr_dis = 2'b00;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] hi, lo;
        logic [64:0] r;

        reset = 1'b1; md_start = 1'b0; md_div = 1'b0; md_signed = 1'b0; md_abort = 1'b0;
        src_a = '0; src_b = '0; hilo_wr_dis = 2'b00; hilo_src = 1'b0; hilo_wr = 1'b0;
        hilo_sel = 1'b0;
        repeat (3) tick();

        // Reset values, observed while reset is still held.
        read_hilo(hi, lo);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        check("reset_md_run", 32'(md_run), 32'h0);
        check("reset_dbz", 32'(div_by_zero), 32'h0);
        tick();
        reset = 1'b0;

        // Pin the reference model to hand-computed values.
        r = model_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("model_sdiv_lo", r[31:0], 32'hFFFF_FFFD);
        check("model_sdiv_hi", r[63:32], 32'hFFFF_FFFF);
        r = model_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("model_smul_hi", r[63:32], 32'h0);
        check("model_smul_lo", r[31:0], 32'h8000_0000);

        // MULTU max x max.
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        check("multu_run_cycles", 32'(n), 32'(LAT_MUL));
        read_hilo(hi, lo);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // Signed DIV -7 / 2.
        start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        check("div_run_cycles", 32'(n), 32'(LAT_DIV));
        read_hilo(hi, lo);
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);

        // Signed MULT -2^31 x -1.
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        read_hilo(hi, lo);
        check("smul_min_hi", hi, 32'h0);
        check("smul_min_lo", lo, 32'h8000_0000);

        // DIVU by zero, then the next start clears the flag.
        start_op(1'b1, 1'b0, 32'h1234, 32'h0);
        wait_done(n);
        check("dbz_run_cycles", 32'(n), 32'(LAT_DIV));
        read_hilo(hi, lo);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        check("dbz_hi", hi, 32'h0000_1234);
        @(negedge clk);
        check("dbz_set", 32'(div_by_zero), 32'h1);
        tick();
        start_op(1'b0, 1'b0, 32'd2, 32'd3);
        @(negedge clk);
        check("dbz_cleared", 32'(div_by_zero), 32'h0);
        tick();
        wait_done(n);
        read_hilo(hi, lo);
        check("multu_small_lo", lo, 32'd6);

        // Abort on busy cycle 10 keeps the preloaded HI/LO.
        move(1'b1, 2'b00, 32'hA);
        move(1'b0, 2'b00, 32'hB);
        start_op(1'b1, 1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        md_abort = 1'b1;
        tick();
        md_abort = 1'b0;
        @(negedge clk);
        check("abort_md_run", 32'(md_run), 32'h0);
        tick();
        read_hilo(hi, lo);
        check("abort_hi", hi, 32'hA);
        check("abort_lo", lo, 32'hB);

        // Move writes and their disables.
        move(1'b0, 2'b00, 32'h55);
        read_hilo(hi, lo);
        check("mtlo_lo", lo, 32'h55);
        move(1'b0, 2'b01, 32'h66);
        read_hilo(hi, lo);
        check("mtlo_disabled_lo", lo, 32'h55);

        // Move and second start while busy are both dropped.
        start_op(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (3) tick();
        hilo_wr = 1'b1; hilo_src = 1'b1;
        start_op(1'b0, 1'b0, 32'h77, 32'd5);
        hilo_wr = 1'b0;
        wait_done(n);
        read_hilo(hi, lo);
        check("busy_ignored_lo", lo, 32'd14);
        check("busy_ignored_hi", hi, 32'd2);
        @(negedge clk);
        check("second_start_dropped", 32'(md_run), 32'h0);
        tick();

        // MULT 3 x -4.
        start_op(1'b0, 1'b1, 32'd3, 32'hFFFF_FFFC);
        wait_done(n);
        check("mult_neg_run_cycles", 32'(n), 32'(LAT_MUL));
        read_hilo(hi, lo);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFF4);

        // Reset in the middle of an operation.
        start_op(1'b0, 1'b0, 32'd9, 32'd9);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midop_reset_md_run", 32'(md_run), 32'h0);
        tick();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 799) == 0);
            md_start    = ($urandom_range(0, 5) == 0);
            md_div      = 1'($urandom_range(0, 1));
            md_signed   = 1'($urandom_range(0, 1));
            md_abort    = ($urandom_range(0, 79) == 0);
            src_a       = pick();
            src_b       = pick();
            hilo_wr     = ($urandom_range(0, 5) == 0);
            hilo_src    = 1'($urandom_range(0, 1));
            hilo_wr_dis = 2'($urandom_range(0, 3));
            hilo_sel    = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0; md_start = 1'b0; md_abort = 1'b0; hilo_wr = 1'b0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
